l2_ram_bank_ctrl: RTL and testbench
===================================

// Module: l2_ram_bank_ctrl
// PURPOSE
// - Parametrised single L2 SRAM bank behind a TCDM slave port; next generation of the fixed-size L2 bank wrappers.
// - Generalises width, depth, base address, interleave factor and read latency.
// - Adds hardware zero-initialisation (scrub) and out-of-range error responses.
// - One instance per interleaved or private bank inside the L2 memory subsystem.
// PARAMETERS
// - ADDR_WIDTH       13            word-address bits; bank holds 2**ADDR_WIDTH words
// - DATA_WIDTH       32            data width; multiple of 8; BE width = DATA_WIDTH/8
// - BASE_ADDR        32'h1C000000  byte address subtracted from add_i
// - INTERLEAVE_BITS  0             log2(number of interleaved banks); 0 = private bank
// - READ_LATENCY     1             request-to-r_valid cycles, legal range 1..3
// - INIT_ON_RESET    1             1 = scrub the whole bank to zero after reset
// PORTS
// - clk_i        in   1             clock
// - rst_ni       in   1             asynchronous active-low reset
// - init_ni      in   1             active-low scrub request, sampled in READY
// - test_mode_i  in   1             1 = skip the post-reset scrub
// - req_i        in   1             TCDM request
// - add_i        in   32            byte address
// - wen_i        in   1             1 = read, 0 = write
// - be_i         in   DATA_WIDTH/8  byte enables, active high
// - wdata_i      in   DATA_WIDTH    write data
// - gnt_o        out  1             grant, combinational
// - r_valid_o    out  1             response valid
// - r_opc_o      out  1             1 = error (out-of-range access)
// - r_rdata_o    out  DATA_WIDTH    read data
// - init_done_o  out  1             bank is initialised and accepting requests
// BEHAVIOUR
// - Clocking: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
// - FSM states: SCRUB, READY.
//   - Reset state is SCRUB when INIT_ON_RESET=1 and test_mode_i=0; otherwise READY.
// - SCRUB:
//   - Writes 0, all BE set, to word 0..2**ADDR_WIDTH-1, one word per cycle.
//   - gnt_o=0 and init_done_o=0 throughout.
//   - Cycle after the last word: move to READY; init_done_o=1 from that cycle.
// - READY:
//   - init_ni=0 -> SCRUB next cycle with the scrub counter cleared.
//   - Responses already in flight still drain with the programmed latency.
//   - gnt_o = req_i in the same cycle; no back-pressure.
// - Address:
//   - off = add_i - BASE_ADDR, 32-bit with wrap.
//   - Word index = off[ADDR_WIDTH+INTERLEAVE_BITS+1 : INTERLEAVE_BITS+2].
//   - Out of range when off >= 2**(ADDR_WIDTH+INTERLEAVE_BITS+2), including wrapped negatives.
//   - Out-of-range request: still granted, macro not enabled, r_opc_o=1, r_rdata_o=0.
// - Macro controls: CEN = ~(granted & in_range), WEN = wen_i, BEN = ~be_i.
// - Response: r_valid_o=1 exactly READ_LATENCY cycles after every grant, reads and writes alike.
//   - r_opc_o is pipelined alongside r_valid_o.
//   - r_rdata_o is unspecified for writes.
// - READ_LATENCY>1: macro Q is registered through READ_LATENCY-1 flop stages.
// - Back-to-back grants are allowed every cycle; the pipeline is fully throughput-1.
// - Reset values:
//   - r_valid_o=0, r_opc_o=0, pipeline data flops=0.
//   - init_done_o=0, or 1 when the reset state is READY.
//   - Scrub counter=0.
//   - gnt_o follows the state: 0 in SCRUB.
// - Reset during SCRUB: scrub restarts from word 0.
// - req_i during the final SCRUB cycle: not granted; granted from the first READY cycle.
// STRUCTURE
// - l2_bank_pkg:
//   - bank_state_e {SCRUB, READY}.
//   - Function for the in-range check.
//   - Constant MAX_READ_LATENCY = 3.
// - Sub-module: generic_memory, instantiated once. Scrub and TCDM write paths are muxed onto its port.
// - Elaboration assertion: 1 <= READ_LATENCY <= 3 and DATA_WIDTH % 8 == 0.
// TESTING
// 1. Scrub, ADDR_WIDTH=4:
//    - Reset release with INIT_ON_RESET=1 -> init_done_o rises after 16 cycles.
//    - gnt_o=0 for req_i=1 throughout the scrub.
//    - Reading word 5 then returns 0.
// 2. Write/read, READ_LATENCY=1:
//    - Write 0xDEADBEEF, be=4'b0101, at BASE_ADDR+0x8, then read it.
//    - Read data 0x00AD00EF.
//    - r_valid_o exactly 1 cycle after each grant.
// 3. READ_LATENCY=3:
//    - Back-to-back reads of 4 distinct addresses.
//    - 4 consecutive r_valid_o pulses starting 3 cycles after the first grant, data in order.
// 4. Interleaving:
//    - INTERLEAVE_BITS=2, write at BASE_ADDR+0x10 -> macro word index 1.
//    - add_i = BASE_ADDR-4 -> r_opc_o=1, r_rdata_o=0, macro untouched.
// 5. init_ni pulse in READY with a read in flight:
//    - The read response is delivered.
//    - init_done_o=0 next cycle and the bank is zeroed again.
// 6. test_mode_i=1 at reset: READY immediately, init_done_o=1, first request granted in cycle 0.

Source files
------------

// File: rtl/l2_bank_pkg.sv
// Shared types and helpers for the L2 SRAM bank controller.
package l2_bank_pkg;

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    READY = 1'b1
  } bank_state_e;

  localparam int unsigned MAX_READ_LATENCY = 3;

  // An offset is inside the bank window when no bit at or above span_bits is set.
  // A wrapped negative offset has its top bits set, so it falls out of range too.
  function automatic logic addr_in_range(input logic [31:0] off, input int unsigned span_bits);
    if (span_bits >= 32) return 1'b1;
    return (off >> span_bits) == 32'd0;
  endfunction

endpackage

// File: rtl/l2_ram_bank_ctrl_if.sv
// TCDM slave bus of one L2 bank.
// Handshake: a request is accepted in any cycle where req and gnt are both high.
// There is no back-pressure once the bank is ready. Every accepted request gets
// exactly one r_valid pulse a fixed number of cycles later. r_opc flags an
// out-of-range access, and r_rdata carries the read data.
interface l2_ram_bank_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic [31:0]             add;
  logic                    wen;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    r_valid;
  logic                    r_opc;
  logic [DATA_WIDTH-1:0]   r_rdata;

  modport master (output req, add, wen, be, wdata, input gnt, r_valid, r_opc, r_rdata);
  modport slave  (input req, add, wen, be, wdata, output gnt, r_valid, r_opc, r_rdata);
endinterface

// File: rtl/l2_ram_bank_ctrl_generic_memory.sv
// Single-port SRAM macro model.
// All of its control inputs are active low.
// Reads return data one cycle after the access.
module generic_memory #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    cen,
  input  logic                    wen,
  input  logic [DATA_WIDTH/8-1:0] ben,
  input  logic [ADDR_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   d,
  output logic [DATA_WIDTH-1:0]   q
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Synchronous access: read into q, or apply a byte-masked write.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (wen) begin
        q <= mem[a];
      end else begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (!ben[b]) mem[a][b*8 +: 8] <= d[b*8 +: 8];
        end
      end
    end
  end
endmodule

// File: rtl/l2_ram_bank_ctrl.sv
// One L2 SRAM bank behind a TCDM slave port.
// The bank provides zero scrubbing, out-of-range error responses and a fixed read latency.
module l2_ram_bank_ctrl
  import l2_bank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 13,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter logic [31:0] BASE_ADDR       = 32'h1C000000,
  parameter int unsigned INTERLEAVE_BITS = 0,
  parameter int unsigned READ_LATENCY    = 1,
  parameter bit          INIT_ON_RESET   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_ni,
  input  logic              test_mode_i,
  l2_ram_bank_ctrl_if.slave bus,
  output logic              init_done_o,
  output logic [0:0]        dbg_state_o
);
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned SPAN_BITS = ADDR_WIDTH + INTERLEAVE_BITS + 2;
  localparam logic [0:0]  ST_SCRUB  = SCRUB;
  localparam logic [0:0]  ST_READY  = READY;

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY ||
      (DATA_WIDTH % 8) != 0 || SPAN_BITS > 32) begin : g_param_check
    $error("l2_ram_bank_ctrl: illegal parameter combination");
  end

  logic [0:0]            state;
  logic [0:0]            rst_state;
  logic [ADDR_WIDTH-1:0] scrub_cnt;
  logic [31:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  granted;

  logic                  mem_cen;
  logic                  mem_wen;
  logic [BE_WIDTH-1:0]   mem_ben;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_q;

  logic [READ_LATENCY-1:0] valid_q;
  logic [READ_LATENCY-1:0] opc_q;
  logic [DATA_WIDTH-1:0]   data_sel;

  // The bank scrubs after reset unless scrubbing is disabled or the chip is in test mode.
  assign rst_state = (INIT_ON_RESET && !test_mode_i) ? ST_SCRUB : ST_READY;

  assign off      = bus.add - BASE_ADDR;
  assign in_range = addr_in_range(off, SPAN_BITS);
  assign word_idx = off[SPAN_BITS-1 : INTERLEAVE_BITS+2];
  assign granted  = bus.req && (state == ST_READY);

  assign bus.gnt     = granted;
  assign init_done_o = (state == ST_READY);
  assign dbg_state_o = state;

  // SCRUB walks every word once and then enters READY.
  // A low init_ni seen in READY restarts the scrub from word 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= rst_state;
      scrub_cnt <= '0;
    end else begin
      case (state)
        ST_SCRUB: begin
          if (scrub_cnt == {ADDR_WIDTH{1'b1}}) begin
            state     <= ST_READY;
            scrub_cnt <= '0;
          end else begin
            scrub_cnt <= scrub_cnt + 1'b1;
          end
        end
        default: begin
          if (!init_ni) begin
            state     <= ST_SCRUB;
            scrub_cnt <= '0;
          end
        end
      endcase
    end
  end

  // The macro port carries zero-writes during scrub and granted in-range TCDM accesses otherwise.
  always_comb begin
    if (state == ST_SCRUB) begin
      mem_cen   = 1'b0;
      mem_wen   = 1'b0;
      mem_ben   = '0;
      mem_addr  = scrub_cnt;
      mem_wdata = '0;
    end else begin
      mem_cen   = ~(granted & in_range);
      mem_wen   = bus.wen;
      mem_ben   = ~bus.be;
      mem_addr  = word_idx;
      mem_wdata = bus.wdata;
    end
  end

  generic_memory #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk (clk_i),
    .cen (mem_cen),
    .wen (mem_wen),
    .ben (mem_ben),
    .a   (mem_addr),
    .d   (mem_wdata),
    .q   (mem_q)
  );

  // Each grant produces one valid/error token, delayed by READ_LATENCY cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      opc_q   <= '0;
    end else begin
      valid_q[0] <= granted;
      opc_q[0]   <= granted & ~in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        opc_q[i]   <= opc_q[i-1];
      end
    end
  end

  assign bus.r_valid = valid_q[READ_LATENCY-1];
  assign bus.r_opc   = opc_q[READ_LATENCY-1];

  // The macro is idle on an error access, so its stale Q output is replaced with zero.
  assign data_sel = opc_q[0] ? '0 : mem_q;

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.r_rdata = data_sel;
  end else begin : g_latn
    logic [READ_LATENCY-2:0][DATA_WIDTH-1:0] data_q;

    // Extra register stages align the read data with the delayed valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q <= '0;
      end else begin
        data_q[0] <= data_sel;
        for (int i = 1; i < READ_LATENCY - 1; i++) data_q[i] <= data_q[i-1];
      end
    end

    assign bus.r_rdata = data_q[READ_LATENCY-2];
  end

endmodule

// File: tb/tb_l2_ram_bank_ctrl.sv
// Bench for l2_ram_bank_ctrl.
// Two banks share one stimulus stream: bank A is a private bank with latency 1,
// and bank B is a 4-way interleaved bank with latency 3.
module tb_l2_ram_bank_ctrl;
  localparam logic [31:0] BASE  = 32'h1C000000;
  localparam int          AW    = 4;
  localparam int          WORDS = 16;
  localparam int          RL_A  = 1;
  localparam int          IB_A  = 0;
  localparam int          RL_B  = 3;
  localparam int          IB_B  = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        opc;
    logic        chk;
    int          due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       init_n = 1'b1;
  logic       test_mode = 1'b0;
  logic       init_done_a, init_done_b;
  logic [0:0] st_a, st_b;
  int         cyc = 0;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  // Reference model: bank contents, readiness and the expected responses.
  logic [31:0] mem_m [2][WORDS];
  bit          ready = 1'b0;
  int          scrub_left = WORDS;
  exp_t        q_a[$];
  exp_t        q_b[$];

  l2_ram_bank_ctrl_if #(.DATA_WIDTH(32)) bus_a ();
  l2_ram_bank_ctrl_if #(.DATA_WIDTH(32)) bus_b ();

  l2_ram_bank_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(BASE),
    .INTERLEAVE_BITS(IB_A), .READ_LATENCY(RL_A), .INIT_ON_RESET(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .init_ni(init_n), .test_mode_i(test_mode),
    .bus(bus_a.slave), .init_done_o(init_done_a), .dbg_state_o(st_a)
  );

  l2_ram_bank_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(BASE),
    .INTERLEAVE_BITS(IB_B), .READ_LATENCY(RL_B), .INIT_ON_RESET(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .init_ni(init_n), .test_mode_i(test_mode),
    .bus(bus_b.slave), .init_done_o(init_done_b), .dbg_state_o(st_b)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic zero_model();
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < WORDS; w++) mem_m[k][w] = '0;
  endtask

  // Computes one bank's response from the address map and applies any write.
  task automatic model_access(input int k, input int ib, input int rl, input logic wen,
                              input logic [31:0] add, input logic [3:0] be,
                              input logic [31:0] wd, output exp_t e);
    logic [31:0] off;
    logic [31:0] span;
    int          idx;
    off   = add - BASE;
    span  = 32'd64 << ib;
    e.due = cyc + rl;
    if (off >= span) begin
      e.opc  = 1'b1;
      e.data = '0;
      e.chk  = 1'b1;
    end else begin
      idx   = int'(off / (32'd4 << ib));
      e.opc = 1'b0;
      if (wen) begin
        e.data = mem_m[k][idx];
        e.chk  = 1'b1;
      end else begin
        e.data = '0;
        e.chk  = 1'b0;
        for (int b = 0; b < 4; b++)
          if (be[b]) mem_m[k][idx][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
  endtask

  // One bus cycle. The task is entered and left 1 time unit after a rising edge.
  task automatic drive(input logic req, input logic [31:0] add, input logic wen,
                       input logic [3:0] be, input logic [31:0] wd, input logic init);
    exp_t e;
    bus_a.req = req; bus_a.add = add; bus_a.wen = wen; bus_a.be = be; bus_a.wdata = wd;
    bus_b.req = req; bus_b.add = add; bus_b.wen = wen; bus_b.be = be; bus_b.wdata = wd;
    init_n = init;
    if (req && ready) begin
      model_access(0, IB_A, RL_A, wen, add, be, wd, e);
      q_a.push_back(e);
      model_access(1, IB_B, RL_B, wen, add, be, wd, e);
      q_b.push_back(e);
    end
    @(negedge clk);
    chk1("gnt_a", bus_a.gnt, req && ready);
    chk1("gnt_b", bus_b.gnt, req && ready);
    chk1("init_done_a", init_done_a, ready);
    chk1("init_done_b", init_done_b, ready);
    chk1("state_a", st_a[0], ready);
    chk1("state_b", st_b[0], ready);
    @(posedge clk);
    #1;
    if (ready) begin
      if (!init) begin
        ready = 1'b0;
        scrub_left = WORDS;
        zero_model();
      end
    end else begin
      scrub_left--;
      if (scrub_left == 0) ready = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, BASE, 1'b1, 4'h0, 32'h0, 1'b1);
  endtask

  // Holds reset for some cycles and checks the reset-time outputs.
  task automatic do_reset(input logic tm, input int hold);
    bus_a.req = 1'b0; bus_b.req = 1'b0; init_n = 1'b1;
    test_mode = tm;
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    chk1("rst_valid_a", bus_a.r_valid, 1'b0);
    chk1("rst_valid_b", bus_b.r_valid, 1'b0);
    chk1("rst_opc_a", bus_a.r_opc, 1'b0);
    chk1("rst_opc_b", bus_b.r_opc, 1'b0);
    chk32("rst_rdata_b", bus_b.r_rdata, 32'h0);
    chk1("rst_init_done_a", init_done_a, tm);
    chk1("rst_init_done_b", init_done_b, tm);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = tm;
    scrub_left = WORDS;
    if (!tm) zero_model();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'd4 * $urandom_range(1, 8);
      1:       return $urandom;
      2, 3:    return BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      default: return BASE + ($urandom_range(0, 79) << 2) + $urandom_range(0, 3);
    endcase
  endfunction

  // Response monitors: an expected entry must appear exactly on its due cycle.
  // No response may appear on any other cycle.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (q_a.size() != 0 && q_a[0].due == cyc) begin
      e = q_a.pop_front();
      chk1("r_valid_a", bus_a.r_valid, 1'b1);
      chk1("r_opc_a", bus_a.r_opc, e.opc);
      if (e.chk) chk32("r_rdata_a", bus_a.r_rdata, e.data);
    end else begin
      chk1("spurious_valid_a", bus_a.r_valid, 1'b0);
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (q_b.size() != 0 && q_b[0].due == cyc) begin
      e = q_b.pop_front();
      chk1("r_valid_b", bus_b.r_valid, 1'b1);
      chk1("r_opc_b", bus_b.r_opc, e.opc);
      if (e.chk) chk32("r_rdata_b", bus_b.r_rdata, e.data);
    end else begin
      chk1("spurious_valid_b", bus_b.r_valid, 1'b0);
    end
  end

  initial begin
    bus_a.req = 1'b0; bus_a.add = '0; bus_a.wen = 1'b1; bus_a.be = '0; bus_a.wdata = '0;
    bus_b.req = 1'b0; bus_b.add = '0; bus_b.wen = 1'b1; bus_b.be = '0; bus_b.wdata = '0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Power-up scrub, interrupted by a second reset, then a full scrub with requests denied.
    do_reset(1'b0, 2);
    for (int i = 0; i < 5; i++) drive(1'b1, rand_addr(), 1'b1, 4'hF, 32'h0, 1'b1);
    do_reset(1'b0, 1);
    for (int i = 0; i < WORDS; i++) drive(1'b1, rand_addr(), 1'b1, 4'hF, $urandom, 1'b1);

    // Directed accesses: scrubbed word, partial write, interleave mapping, error range.
    drive(1'b1, BASE + 32'h14, 1'b1, 4'hF, 32'h0, 1'b1);
    drive(1'b1, BASE + 32'h8, 1'b0, 4'b0101, 32'hDEADBEEF, 1'b1);
    drive(1'b1, BASE + 32'h8, 1'b1, 4'hF, 32'h0, 1'b1);
    drive(1'b1, BASE + 32'h10, 1'b0, 4'hF, 32'h12345678, 1'b1);
    drive(1'b1, BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b1);
    drive(1'b1, BASE + 32'h4, 1'b1, 4'hF, 32'h0, 1'b1);
    drive(1'b1, BASE - 32'h4, 1'b0, 4'hF, 32'hFFFFFFFF, 1'b1);
    drive(1'b1, BASE - 32'h4, 1'b1, 4'hF, 32'h0, 1'b1);
    drive(1'b1, BASE + 32'h40, 1'b1, 4'hF, 32'h0, 1'b1);
    drive(1'b1, BASE + 32'h100, 1'b1, 4'hF, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, BASE + 32'h8 * i, 1'b0, 4'hF, $urandom, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, BASE + 32'h8 * i, 1'b1, 4'hF, 32'h0, 1'b1);
    idle(4);

    // Re-scrub requested while a read is still in flight.
    drive(1'b1, BASE + 32'h8, 1'b1, 4'hF, 32'h0, 1'b1);
    drive(1'b0, BASE, 1'b1, 4'h0, 32'h0, 1'b0);
    idle(WORDS + 1);
    drive(1'b1, BASE + 32'h8, 1'b1, 4'hF, 32'h0, 1'b1);
    drive(1'b1, BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b1);

    // Random traffic with occasional re-scrub requests.
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 3) != 0), rand_addr(), $urandom_range(0, 1),
            4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 149) != 0));
    idle(WORDS + 4);

    // Test-mode reset: the bank is ready at once and its contents are kept.
    do_reset(1'b1, 2);
    drive(1'b1, BASE + 32'h8, 1'b1, 4'hF, 32'h0, 1'b1);
    for (int i = 0; i < 40; i++)
      drive(($urandom_range(0, 3) != 0), rand_addr(), $urandom_range(0, 1),
            4'($urandom_range(0, 15)), $urandom, 1'b1);
    idle(6);

    chk1("drain_a", q_a.size() == 0, 1'b1);
    chk1("drain_b", q_b.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
